soc_ahb4_ext_responder: RTL and testbench
=========================================

# soc_ahb4_ext_responder

AHB4-Lite slave that terminates the external AHB master port of the `mpsoc3d_riscv` system (`ahb4_ext_*`). It sits on the bus side opposite the system's external bus master and serves as a word-organised local memory with programmable wait states. Transfers outside its window, and transfers that are misaligned or of illegal size, get the standard two-cycle ERROR response. It replaces the current `'x` tie-off on `ahb4_ext_hrdata_o`/`hready_o`/`hresp_o`, giving benches and FPGA top levels a defined external target.

## Interface
- `PLEN`, 32: address width.
- `XLEN`, 32: data width. Fixed at 32.
- `DEPTH`, 1024: memory size in 32-bit words. Must be a power of two.
- `BASE`, 32'h8000_0000: byte base address of the window. Must be aligned to `DEPTH*4`.
- `WAIT_STATES`, 1: number of inserted low-`hreadyout` cycles per OKAY transfer. Range 0..15.

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ahb4_hsel_i` in 1: slave select.
- `ahb4_haddr_i` in PLEN: address.
- `ahb4_hwdata_i` in XLEN: write data, valid in the data phase.
- `ahb4_hwrite_i` in 1: 1 = write.
- `ahb4_hsize_i` in 3: 0 = byte, 1 = half, 2 = word. Other values are illegal.
- `ahb4_hburst_i` in 3: ignored. Every beat is treated independently.
- `ahb4_hprot_i` in 4: ignored.
- `ahb4_htrans_i` in 2: 0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- `ahb4_hmastlock_i` in 1: ignored.
- `ahb4_hready_i` in 1: bus-level HREADY.
- `ahb4_hrdata_o` out XLEN: read data.
- `ahb4_hreadyout_o` out 1: slave ready.
- `ahb4_hresp_o` out 1: 0 = OKAY, 1 = ERROR.

## Operation
- **Address phase accept**: occurs when `hsel_i & hready_i & htrans_i[1]`. On accept, register addr, write, size and an error flag.
- **Error flag** is set if any of the following holds:
  - the address is outside `[BASE, BASE+DEPTH*4)`;
  - `hsize > 2`;
  - `hsize == 1` and `addr[0] != 0`;
  - `hsize == 2` and `addr[1:0] != 0`.
- **IDLE/BUSY, or `hsel_i` low**: no transfer. The next cycle returns `hreadyout=1`, `hresp=0` (zero-wait OKAY).
- **FSM states**:
  - `IDLE`:
    - accept with error flag → `ERR1`;
    - accept without error and `WAIT_STATES > 0` → `WAIT`, counter loaded with `WAIT_STATES-1`;
    - accept without error and `WAIT_STATES == 0` → `DATA`.
  - `WAIT`: `hreadyout=0`, `hresp=0`. Counter decrements each cycle; at 0 → `DATA`.
  - `DATA`: `hreadyout=1`, `hresp=0`.
    - Reads drive `hrdata` = `mem[addr[log2(DEPTH)+1:2]]`, the full word regardless of size.
    - Writes commit `hwdata_i` at the end of this cycle, only on byte lanes selected by size and `addr[1:0]`.
    - This cycle may simultaneously accept the next address phase. Next state follows the `IDLE` rules above; with no new accept → `IDLE`.
  - `ERR1`: `hreadyout=0`, `hresp=1`. Always → `ERR2`.
  - `ERR2`: `hreadyout=1`, `hresp=1`. No memory access. May accept the next address phase, with the same next-state rules as `DATA`.
- **`hrdata`**: 0 in every cycle other than `DATA` of a read.
- **Memory contents**: not reset.
- **Reset mid-transfer**: aborts the transfer. No write commits, and the FSM goes to `IDLE`.

## Timing
- **Reset values**: `hreadyout_o=1`, `hresp_o=0`, `hrdata_o=0`, state `IDLE`, counter 0.
- **OKAY transfer**: data phase lasts `WAIT_STATES+1` cycles after the address-phase cycle.
- **ERROR response**: exactly 2 data-phase cycles, independent of `WAIT_STATES`.
- **Back-to-back transfers**: fully pipelined. With `WAIT_STATES=0`, a NONSEQ/SEQ stream sustains 1 beat/cycle.
- **Write followed by read to the same word**: the read's `DATA` cycle returns the newly written bytes (write commits before the read's data phase).
- **Registered vs combinational outputs**: `hreadyout`/`hresp` are registered state decodes. `hrdata` is a combinational read from the registered address.

## Test plan
- **Reset**: assert `rst` 3 cycles with random inputs → `hreadyout=1`, `hresp=0`, `hrdata=0` every cycle.
- **Word write/read, `WAIT_STATES=1`**: write 32'hDEADBEEF @ BASE+8, then read @ BASE+8 → each data phase is 1 low + 1 high `hreadyout`; read returns 32'hDEADBEEF with OKAY.
- **Byte lanes**: preload word 0 with 32'h0; write byte 8'hAA @ BASE+1 and half 16'h1234 @ BASE+2 (`hwdata` lanes placed accordingly); read word → 32'h1234AA00.
- **Errors**:
  - read @ BASE+DEPTH*4 → ERR1 then ERR2;
  - word write @ BASE+2 → two-cycle ERROR, and a memory check shows no change;
  - `hsize=3` → ERROR.
- **Pipelining, `WAIT_STATES=0`**: 4 consecutive NONSEQ writes, then 4 reads, to BASE..BASE+12 with data 1..4 → `hreadyout` stays 1 throughout; reads return 1,2,3,4 on consecutive cycles. BUSY/IDLE inserted mid-stream → OKAY with no access.
- **Reset mid-wait**: `WAIT_STATES=3`, issue a write, assert `rst` in the 2nd `WAIT` cycle → `hreadyout` returns to 1, and a subsequent read shows the old data.

Source files
------------

// File: rtl/soc_ahb4_ext_responder.sv
// rtl/soc_ahb4_ext_responder.sv - AHB4-Lite word-organised memory slave with programmable wait states
module soc_ahb4_ext_responder #(
  parameter int unsigned     PLEN        = 32,
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH       = 1024,
  parameter logic [PLEN-1:0] BASE        = 32'h8000_0000,
  parameter int unsigned     WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ahb4_hsel_i,
  input  logic [PLEN-1:0] ahb4_haddr_i,
  input  logic [XLEN-1:0] ahb4_hwdata_i,
  input  logic            ahb4_hwrite_i,
  input  logic [2:0]      ahb4_hsize_i,
  input  logic [2:0]      ahb4_hburst_i,
  input  logic [3:0]      ahb4_hprot_i,
  input  logic [1:0]      ahb4_htrans_i,
  input  logic            ahb4_hmastlock_i,
  input  logic            ahb4_hready_i,
  output logic [XLEN-1:0] ahb4_hrdata_o,
  output logic            ahb4_hreadyout_o,
  output logic            ahb4_hresp_o
);
  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned AW = IW + 2;
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [2:0]      size_q, size_d;
  logic [XLEN-1:0] mem [DEPTH];

  logic       can_accept, accept, in_win, err;
  logic [3:0] be;
  logic       unused_ok;

  assign unused_ok = ^{ahb4_hburst_i, ahb4_hprot_i, ahb4_hmastlock_i};

  // New address phases are only taken while this slave is driving hreadyout high.
  assign can_accept = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
  assign accept     = ahb4_hsel_i & ahb4_hready_i & ahb4_htrans_i[1] & can_accept;
  assign in_win     = (ahb4_haddr_i[PLEN-1:AW] == BASE[PLEN-1:AW]);

  always_comb begin
    err = !in_win;
    if (ahb4_hsize_i > 3'd2) err = 1'b1;
    if (ahb4_hsize_i == 3'd1 && ahb4_haddr_i[0] != 1'b0) err = 1'b1;
    if (ahb4_hsize_i == 3'd2 && ahb4_haddr_i[1:0] != 2'b00) err = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      addr_d  = ahb4_haddr_i[AW-1:0];
      write_d = ahb4_hwrite_i;
      size_d  = ahb4_hsize_i;
      if (err) begin
        state_d = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = S_WAIT;
        cnt_d   = WS_LOAD;
      end else begin
        state_d = S_DATA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      3'd0:    be = 4'b0001 << addr_q[1:0];
      3'd1:    be = 4'b0011 << addr_q[1:0];
      default: be = 4'b1111;
    endcase
  end

  // Reset wins over the commit so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_DATA && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr_q[AW-1:2]][8*b +: 8] <= ahb4_hwdata_i[8*b +: 8];
      end
    end
  end

  assign ahb4_hreadyout_o = !((state_q == S_WAIT) || (state_q == S_ERR1));
  assign ahb4_hresp_o     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign ahb4_hrdata_o    = (state_q == S_DATA && !write_q) ? mem[addr_q[AW-1:2]] : '0;

endmodule

// File: tb/tb_soc_ahb4_ext_responder.sv
// tb/tb_soc_ahb4_ext_responder.sv - table-driven scoreboard bench for soc_ahb4_ext_responder
module tb_soc_ahb4_ext_responder;
  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr, hwdata;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hmastlock;
  int          act;
  logic [2:0]  rdy, rsp;
  logic [31:0] rd [3];
  int          ws_of [3] = '{1, 0, 3};

  int    n_checks, n_fail;
  beat_t vecs[$];
  beat_t sb[$];

  always #5 clk = ~clk;

  soc_ahb4_ext_responder #(.WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .ahb4_hsel_i(hsel && act == 0), .ahb4_haddr_i(haddr),
    .ahb4_hwdata_i(hwdata), .ahb4_hwrite_i(hwrite), .ahb4_hsize_i(hsize),
    .ahb4_hburst_i(hburst), .ahb4_hprot_i(hprot), .ahb4_htrans_i(htrans),
    .ahb4_hmastlock_i(hmastlock), .ahb4_hready_i(rdy[0]), .ahb4_hrdata_o(rd[0]),
    .ahb4_hreadyout_o(rdy[0]), .ahb4_hresp_o(rsp[0]));

  soc_ahb4_ext_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .ahb4_hsel_i(hsel && act == 1), .ahb4_haddr_i(haddr),
    .ahb4_hwdata_i(hwdata), .ahb4_hwrite_i(hwrite), .ahb4_hsize_i(hsize),
    .ahb4_hburst_i(hburst), .ahb4_hprot_i(hprot), .ahb4_htrans_i(htrans),
    .ahb4_hmastlock_i(hmastlock), .ahb4_hready_i(rdy[1]), .ahb4_hrdata_o(rd[1]),
    .ahb4_hreadyout_o(rdy[1]), .ahb4_hresp_o(rsp[1]));

  soc_ahb4_ext_responder #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .ahb4_hsel_i(hsel && act == 2), .ahb4_haddr_i(haddr),
    .ahb4_hwdata_i(hwdata), .ahb4_hwrite_i(hwrite), .ahb4_hsize_i(hsize),
    .ahb4_hburst_i(hburst), .ahb4_hprot_i(hprot), .ahb4_htrans_i(htrans),
    .ahb4_hmastlock_i(hmastlock), .ahb4_hready_i(rdy[2]), .ahb4_hrdata_o(rd[2]),
    .ahb4_hreadyout_o(rdy[2]), .ahb4_hresp_o(rsp[2]));

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic beat_t wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d, input logic e);
    beat_t b;
    b = '{sel: 1'b1, trans: 2'd2, addr: a, write: 1'b1, size: s, wdata: d, err: e, rdata: 32'h0};
    return b;
  endfunction

  function automatic beat_t rdv(input logic [31:0] a, input logic [2:0] s, input logic [31:0] exp, input logic e);
    beat_t b;
    b = '{sel: 1'b1, trans: 2'd2, addr: a, write: 1'b0, size: s, wdata: 32'h0, err: e, rdata: exp};
    return b;
  endfunction

  function automatic beat_t nx(input logic sel, input logic [1:0] tr);
    beat_t b;
    b = '{sel: sel, trans: tr, addr: BASE, write: 1'b0, size: 3'd2, wdata: 32'h0, err: 1'b0, rdata: 32'h0};
    return b;
  endfunction

  task automatic drive(input beat_t b);
    hsel   = b.sel;
    htrans = b.trans;
    haddr  = b.addr;
    hwrite = b.write;
    hsize  = b.size;
  endtask

  // Cycle-level AHB master: address phases from vecs, accepted beats pushed to sb,
  // completed data phases popped and compared.
  task automatic run_vectors(input int inst);
    beat_t cur;
    int    idx, lows, guard;
    logic  r;
    act = inst; idx = 0; lows = 0; guard = 0;
    sb.delete();
    @(posedge clk); #1;
    cur = vecs[0]; idx = 1;
    drive(cur);
    while (guard < 400) begin
      guard++;
      @(negedge clk);
      r = rdy[inst];
      if (sb.size() > 0) begin
        if (!r) begin
          lows++;
          chk("wait_resp", 32'(rsp[inst]), 32'(sb[0].err));
          chk("wait_rdata", rd[inst], 32'h0);
        end else begin
          chk("resp", 32'(rsp[inst]), 32'(sb[0].err));
          chk("rdata", rd[inst], sb[0].rdata);
          chk("low_cycles", 32'(lows), sb[0].err ? 32'd1 : 32'(ws_of[inst]));
          void'(sb.pop_front());
          lows = 0;
        end
      end else begin
        chk("idle_ready", 32'(r), 32'd1);
        chk("idle_resp", 32'(rsp[inst]), 32'd0);
        chk("idle_rdata", rd[inst], 32'h0);
      end
      @(posedge clk); #1;
      if (r) begin
        if (cur.sel && cur.trans[1]) begin
          sb.push_back(cur);
          hwdata = cur.wdata;
        end
        if (idx < vecs.size()) begin
          cur = vecs[idx];
          idx++;
        end else begin
          cur = nx(1'b0, 2'd0);
        end
        drive(cur);
        if (idx >= vecs.size() && !(cur.sel && cur.trans[1]) && sb.size() == 0) break;
      end
    end
    if (guard >= 400) chk("timeout", 32'(guard), 32'd0);
    vecs.delete();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; act = 0;
    rst = 1'b1; drive(nx(1'b0, 2'd0));
    hwdata = 32'h0; hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0;

    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      hsel = 1'($urandom); htrans = 2'($urandom); hwrite = 1'($urandom);
      haddr = BASE + 32'($urandom_range(0, 15) << 2); hsize = 3'($urandom_range(0, 2));
      hwdata = $urandom; hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
      @(negedge clk);
      chk("rst_ready", 32'(rdy[0]), 32'd1);
      chk("rst_resp", 32'(rsp[0]), 32'd0);
      chk("rst_rdata", rd[0], 32'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0; drive(nx(1'b0, 2'd0)); hwdata = 32'h0;

    vecs.push_back(wr (BASE + 8, 3'd2, 32'hDEADBEEF, 1'b0));
    vecs.push_back(rdv(BASE + 8, 3'd2, 32'hDEADBEEF, 1'b0));
    run_vectors(0);

    vecs.push_back(wr (BASE + 0, 3'd2, 32'h0000_0000, 1'b0));
    vecs.push_back(wr (BASE + 1, 3'd0, 32'h0000_AA00, 1'b0));
    vecs.push_back(wr (BASE + 2, 3'd1, 32'h1234_0000, 1'b0));
    vecs.push_back(rdv(BASE + 0, 3'd2, 32'h1234_AA00, 1'b0));
    run_vectors(0);

    vecs.push_back(rdv(BASE + 32'd4096, 3'd2, 32'h0, 1'b1));
    vecs.push_back(wr (BASE + 2, 3'd2, 32'hFFFF_FFFF, 1'b1));
    vecs.push_back(rdv(BASE + 0, 3'd2, 32'h1234_AA00, 1'b0));
    vecs.push_back(rdv(BASE + 0, 3'd3, 32'h0, 1'b1));
    vecs.push_back(wr (BASE + 1, 3'd1, 32'hFFFF_FFFF, 1'b1));
    vecs.push_back(rdv(BASE - 4, 3'd2, 32'h0, 1'b1));
    vecs.push_back(rdv(BASE + 1, 3'd0, 32'h1234_AA00, 1'b0));
    run_vectors(0);

    for (int i = 0; i < 4; i++) vecs.push_back(wr(BASE + 32'(4 * i), 3'd2, 32'(i + 1), 1'b0));
    for (int i = 0; i < 4; i++) vecs.push_back(rdv(BASE + 32'(4 * i), 3'd2, 32'(i + 1), 1'b0));
    vecs.push_back(rdv(BASE + 0, 3'd2, 32'd1, 1'b0));
    vecs.push_back(nx(1'b1, 2'd1));
    vecs.push_back(nx(1'b1, 2'd0));
    vecs.push_back(nx(1'b0, 2'd2));
    vecs.push_back(rdv(BASE + 4, 3'd2, 32'd2, 1'b0));
    vecs.push_back(rdv(BASE + 32'd4096, 3'd2, 32'h0, 1'b1));
    vecs.push_back(rdv(BASE + 12, 3'd2, 32'd4, 1'b0));
    run_vectors(1);

    vecs.push_back(wr(BASE + 16, 3'd2, 32'h1111_1111, 1'b0));
    run_vectors(2);

    // Abort a write with reset during its second wait cycle.
    act = 2;
    @(posedge clk); #1;
    drive(wr(BASE + 16, 3'd2, 32'h2222_2222, 1'b0));
    @(posedge clk); #1;
    drive(nx(1'b0, 2'd0)); hwdata = 32'h2222_2222;
    @(negedge clk);
    chk("mid_wait1_ready", 32'(rdy[2]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_wait2_ready", 32'(rdy[2]), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(rdy[2]), 32'd1);
    chk("post_rst_resp", 32'(rsp[2]), 32'd0);
    chk("post_rst_rdata", rd[2], 32'h0);

    vecs.push_back(rdv(BASE + 16, 3'd2, 32'h1111_1111, 1'b0));
    run_vectors(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
